// File: rtl/bmc_pkg.sv
// Shared types and default constants for the biphase-mark decoder.
// Pure declarations; no latency or flow control of its own.
package bmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    HALF = 2'd2
  } bmc_state_e;

  localparam int WORD_W = 17;
  localparam int CNT_W  = 7;

  localparam int HALF_MAX_DEF   = 36;
  localparam int TIMEOUT_DEF    = 64;
  localparam int GLITCH_MIN_DEF = 4;

  localparam logic [4:0] BCNT_MAX = 5'd31;

endpackage

// File: rtl/bmc_edge_sync.sv
// Two-flop synchronizers for data/envelope plus a registered any-edge detector on data.
// Latency: edge_det pulses 3 cycles after a pin transition, env follows the pin by 2 cycles; no backpressure.
module bmc_edge_sync (
  input  logic clk_25MHz,
  input  logic rst_n,
  input  logic data_wire,
  input  logic envelop_wire,
  output logic edge_det,
  output logic env
);

  logic [1:0] data_sync;
  logic [1:0] env_sync;
  logic       data_prev;

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      data_sync <= 2'b00;
      env_sync  <= 2'b00;
      data_prev <= 1'b0;
      edge_det  <= 1'b0;
    end else begin
      data_sync <= {data_sync[0], data_wire};
      env_sync  <= {env_sync[0], envelop_wire};
      data_prev <= data_sync[1];
      edge_det  <= data_sync[1] ^ data_prev;
    end
  end

  assign env = env_sync[1];

endmodule

// File: rtl/bmc_decoder.sv
// Biphase-mark decoder: interval timing + IDLE/SYNC/HALF FSM; BMC_GLITCH_FILTER_EN drops edges closer than GLITCH_MIN.
// Latency: 4 cycles pin-to-bit_valid, 3 cycles envelope-fall-to-frame_done; no backpressure, pulses are never stalled.
module bmc_decoder
  import bmc_pkg::*;
#(
  parameter int HALF_MAX   = HALF_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int GLITCH_MIN = GLITCH_MIN_DEF
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic              envelop_wire,
  input  logic              data_wire,
  output logic              bit_valid,
  output logic              bit_value,
  output logic [WORD_W-1:0] shift_word,
  output logic [4:0]        bit_count,
  output logic              frame_done,
  output logic              bmc_error
);

`ifdef BMC_GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  // The counter reads elapsed-1 when an edge pulse arrives, so every limit is offset by one.
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SHORT_LIM   = CNT_W'(HALF_MAX - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GLITCH_LIM  = CNT_W'(GLITCH_MIN - 1);

  logic             edge_det;
  logic             env;
  logic [CNT_W-1:0] interval_cnt;
  logic             is_short;
  logic             is_glitch;
  logic             timed_out;
  logic             accepted;

  bmc_state_e state, state_nxt;
  logic       emit;
  logic       emit_val;
  logic       err_nxt;
  logic       done_nxt;
  logic       start;

  bmc_edge_sync u_edge_sync (
    .clk_25MHz    (clk_25MHz),
    .rst_n        (rst_n),
    .data_wire    (data_wire),
    .envelop_wire (envelop_wire),
    .edge_det     (edge_det),
    .env          (env)
  );

  assign is_short  = interval_cnt < SHORT_LIM;
  assign is_glitch = interval_cnt < GLITCH_LIM;
  assign timed_out = interval_cnt >= TIMEOUT_LIM;
  assign accepted  = edge_det && !(FILTER_ON && is_glitch);

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      interval_cnt <= '0;
    end else if (accepted) begin
      interval_cnt <= '0;
    end else if (interval_cnt != CNT_SAT) begin
      interval_cnt <= interval_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Envelope loss outranks an edge; an edge outranks a timeout in the same cycle.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_val  = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (accepted && env) begin
          state_nxt = SYNC;
          start     = 1'b1;
        end
      end
      SYNC, HALF: begin
        if (!env) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (accepted) begin
          if (state == SYNC) begin
            if (is_short) begin
              state_nxt = HALF;
            end else begin
              emit     = 1'b1;
              emit_val = 1'b0;
            end
          end else begin
            state_nxt = SYNC;
            if (is_short) begin
              emit     = 1'b1;
              emit_val = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
          end
        end else if (timed_out) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      bit_valid  <= 1'b0;
      bit_value  <= 1'b0;
      frame_done <= 1'b0;
      bmc_error  <= 1'b0;
      bit_count  <= '0;
      shift_word <= '0;
    end else begin
      bit_valid  <= emit;
      frame_done <= done_nxt;
      bmc_error  <= err_nxt;
      if (emit) begin
        bit_value  <= emit_val;
        shift_word <= {shift_word[WORD_W-2:0], emit_val};
      end
      if (start) begin
        bit_count <= '0;
      end else if (emit && bit_count != BCNT_MAX) begin
        bit_count <= bit_count + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_bmc_decoder.sv
// Randomized scoreboard bench for bmc_decoder with an interval-level BMC reference model.
`timescale 1ns/1ps
module tb_bmc_decoder;

  localparam int HALF_MAX   = 36;
  localparam int TIMEOUT    = 64;
  localparam int GLITCH_MIN = 4;
  localparam int PIN2OUT    = 4;
  localparam int ENV2DONE   = 3;
`ifdef BMC_GLITCH_FILTER_EN
  localparam bit FILTER = 1'b1;
`else
  localparam bit FILTER = 1'b0;
`endif
  localparam int K_BIT  = 0;
  localparam int K_ERR  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int          kind;
    logic        val;
    int          cyc;
    logic [16:0] sw;
    logic [4:0]  cnt;
  } ev_t;

  logic        clk_25MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        envelop_wire = 1'b0;
  logic        data_wire = 1'b0;
  logic        bit_valid;
  logic        bit_value;
  logic [16:0] shift_word;
  logic [4:0]  bit_count;
  logic        frame_done;
  logic        bmc_error;

  bmc_decoder #(
    .HALF_MAX   (HALF_MAX),
    .TIMEOUT    (TIMEOUT),
    .GLITCH_MIN (GLITCH_MIN)
  ) dut (
    .clk_25MHz    (clk_25MHz),
    .rst_n        (rst_n),
    .envelop_wire (envelop_wire),
    .data_wire    (data_wire),
    .bit_valid    (bit_valid),
    .bit_value    (bit_value),
    .shift_word   (shift_word),
    .bit_count    (bit_count),
    .frame_done   (frame_done),
    .bmc_error    (bmc_error)
  );

  always #20 clk_25MHz = ~clk_25MHz;

  int cyc = 0;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int done_seen = 0;

  // Reference model: decode from pin-level edge intervals.
  ev_t         exp_q[$];
  int          ivq[$];
  int          m_last;
  bit          m_active;
  bit          m_half;
  logic [16:0] m_sw;
  int          m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input logic val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    e.sw   = m_sw;
    e.cnt  = 5'(m_cnt);
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    m_last   = -1000;
    m_active = 1'b0;
    m_half   = 1'b0;
    m_sw     = '0;
    m_cnt    = 0;
    exp_q.delete();
  endtask

  task automatic model_edge(input int p);
    int ival;
    ival = p - m_last;
    if (FILTER && ival < GLITCH_MIN) return;
    m_last = p;
    if (!m_active) begin
      if (envelop_wire) begin
        m_active = 1'b1;
        m_half   = 1'b0;
        m_cnt    = 0;
      end
      return;
    end
    if (!m_half) begin
      if (ival < HALF_MAX) m_half = 1'b1;
      else begin
        m_sw = {m_sw[15:0], 1'b0};
        if (m_cnt < 31) m_cnt++;
        push_ev(K_BIT, 1'b0, p + PIN2OUT);
      end
    end else begin
      m_half = 1'b0;
      if (ival < HALF_MAX) begin
        m_sw = {m_sw[15:0], 1'b1};
        if (m_cnt < 31) m_cnt++;
        push_ev(K_BIT, 1'b1, p + PIN2OUT);
      end else begin
        push_ev(K_ERR, 1'b0, p + PIN2OUT);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  task automatic edge_after(input int n);
    tick(n);
    data_wire = ~data_wire;
    model_edge(cyc);
  endtask

  task automatic add_bit(input logic b, input int sh, input int lg);
    if (b) begin
      ivq.push_back(sh);
      ivq.push_back(sh);
    end else begin
      ivq.push_back(lg);
    end
  endtask

  task automatic add_rand_bits(input int n);
    for (int i = 0; i < n; i++)
      add_bit(1'($urandom_range(0, 1)), $urandom_range(10, 33), $urandom_range(39, 60));
  endtask

  task automatic run_burst();
    edge_after(12);
    foreach (ivq[i]) edge_after(ivq[i]);
    ivq.delete();
  endtask

  task automatic end_timeout();
    if (m_active) push_ev(K_DONE, 1'b0, m_last + TIMEOUT + PIN2OUT);
    m_active = 1'b0;
    tick(TIMEOUT + 20);
  endtask

  task automatic end_envfall(input int gap);
    tick(gap);
    envelop_wire = 1'b0;
    if (m_active) push_ev(K_DONE, 1'b0, cyc + ENV2DONE);
    m_active = 1'b0;
    tick(20);
    envelop_wire = 1'b1;
    tick(10);
  endtask

  always @(negedge clk_25MHz) begin
    int  k;
    ev_t e;
    if (bit_valid || bmc_error || frame_done) begin
      k = bit_valid ? K_BIT : (bmc_error ? K_ERR : K_DONE);
      if (bmc_error) err_seen++;
      if (frame_done) done_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", k, e.kind);
        check("event_cycle", cyc, e.cyc);
        if (k == K_BIT) check("bit_value", 32'(bit_value), 32'(e.val));
        check("shift_word", 32'(shift_word), 32'(e.sw));
        check("bit_count", 32'(bit_count), 32'(e.cnt));
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk_25MHz);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d, expected completion", cyc);
    errors++;
    checks++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [4:0] pat;
    int e0;
    int d0;
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_25MHz);
      data_wire    = 1'($urandom_range(0, 1));
      envelop_wire = 1'($urandom_range(0, 1));
      check("reset_outputs",
            32'({bit_valid, bit_value, frame_done, bmc_error, bit_count, shift_word}), 32'd0);
    end
    data_wire    = 1'b0;
    envelop_wire = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    envelop_wire = 1'b1;
    tick(10);

    // Nominal timing, bits 0,1,1,1,0
    pat = 5'b01110;
    for (int i = 4; i >= 0; i--) add_bit(pat[i], 24, 48);
    run_burst();
    end_timeout();
    check("nominal_word", 32'(shift_word[4:0]), 32'(pat));
    check("nominal_count", 32'(bit_count), 32'd5);

    // Same bits at the edges of the tolerance window
    for (int i = 4; i >= 0; i--)
      add_bit(pat[i], ($urandom_range(0, 1) != 0) ? 15 : 33, ($urandom_range(0, 1) != 0) ? 39 : 57);
    e0 = err_seen;
    run_burst();
    end_timeout();
    check("margin_word", 32'(shift_word[4:0]), 32'(pat));
    check("margin_errors", err_seen - e0, 0);

    // Half interval followed by a full one: coding violation, then a clean 0
    ivq.push_back(24);
    ivq.push_back(48);
    ivq.push_back(48);
    e0 = err_seen;
    run_burst();
    end_timeout();
    check("violation_errors", err_seen - e0, 1);
    check("violation_count", 32'(bit_count), 32'd1);
    check("violation_bit", 32'(shift_word[0]), 32'd0);

    // Envelope drop after three bits
    add_rand_bits(3);
    run_burst();
    end_envfall(10);
    check("envfall_count", 32'(bit_count), 32'd3);

    // Two-cycle glitches: one at the start of a full bit, one in the middle
    ivq = '{1, 2, 45, 48, 23, 2, 23, 48, 48};
    e0 = err_seen;
    run_burst();
    end_timeout();
    check("glitch_errors", err_seen - e0, FILTER ? 0 : 1);

    // Long burst: bit_count saturation and shift_word wrap
    add_rand_bits(35);
    run_burst();
    end_timeout();
    check("saturated_count", 32'(bit_count), 32'd31);

    for (int r = 0; r < 6; r++) begin
      add_rand_bits($urandom_range(4, 12));
      run_burst();
      if ($urandom_range(0, 1) != 0) end_timeout();
      else end_envfall($urandom_range(8, 40));
    end

    // Reset in the middle of a burst must not produce frame_done
    add_rand_bits(3);
    run_burst();
    tick(10);
    d0 = done_seen;
    rst_n = 1'b0;
    model_reset();
    data_wire    = 1'b0;
    envelop_wire = 1'b0;
    tick(5);
    check("midreset_outputs",
          32'({bit_valid, bit_value, frame_done, bmc_error, bit_count, shift_word}), 32'd0);
    tick(10);
    rst_n = 1'b1;
    tick(TIMEOUT + 20);
    check("midreset_no_done", done_seen - d0, 0);
    envelop_wire = 1'b1;
    tick(10);
    add_bit(1'b1, 24, 48);
    add_bit(1'b0, 24, 48);
    add_bit(1'b1, 24, 48);
    run_burst();
    end_timeout();
    check("resume_word", 32'(shift_word), 32'h5);
    check("resume_count", 32'(bit_count), 32'd3);

    tick(20);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
